// File: rtl/instr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_if
// Bundles the two handshakes of the instruction prefetch queue:
//   - instruction memory read port (req/ack with address and return data)
//   - decode-side instruction stream (valid/ready with instruction and PC)
// Modports:
//   master : the prefetch queue (drives mem_req/mem_addr and out_*)
//   slave  : memory + decode side (drives mem_ack/mem_rdata and out_ready)
// -----------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
   parameter int DATA_W = 19,
   parameter int ADDR_W = 19
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              out_ready;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      output out_valid,
      output out_instr,
      output out_pc,
      input  out_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata,
      input  out_valid,
      input  out_instr,
      input  out_pc,
      output out_ready
   );
endinterface

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
// Instruction fetch front-end. Owns the fetch PC, issues one word read at a
// time to instruction memory, buffers returned words with their PC in a
// DEPTH-entry FIFO and presents the head to decode. A redirect flushes the
// queue, reloads the fetch PC and squashes any read still in flight.
//
// Ports:
//   clk            : clock, all state on rising edge
//   reset          : synchronous active-low reset
//   halt           : stop issuing new reads (queued entries still drain)
//   redirect_valid : flush queue and load fetch PC from redirect_pc
//   redirect_pc    : new fetch PC
//   bus (master)   : mem_req/mem_addr/mem_ack/mem_rdata and
//                    out_valid/out_instr/out_pc/out_ready
//   perf_fetch_cnt, perf_squash_cnt : only when PREFETCH_PERF_EN is defined
//
// Optional feature macro: PREFETCH_PERF_EN (adds 32-bit fetch/squash counters)
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
   parameter int                DATA_W   = 19,
   parameter int                ADDR_W   = 19,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    halt,
   input  logic                    redirect_valid,
   input  logic [ADDR_W-1:0]       redirect_pc,
   instr_prefetch_queue_if.master  bus
`ifdef PREFETCH_PERF_EN
   ,
   output logic [31:0]             perf_fetch_cnt,
   output logic [31:0]             perf_squash_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SQUASH = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;

   logic [DATA_W-1:0] r_q_instr [DEPTH];
   logic [ADDR_W-1:0] r_q_pc    [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_instr;
   logic [ADDR_W-1:0] r_out_pc;

   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count_after_pop;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [PTR_W-1:0]  w_rd_ptr_nxt;
   logic [DATA_W-1:0] w_head_instr_nxt;
   logic [ADDR_W-1:0] w_head_pc_nxt;

   // Issue only from IDLE: no read is outstanding there, so count alone
   // decides whether a slot is free for the word being requested.
   assign w_issue = (r_state == ST_IDLE) && !halt && !redirect_valid && (r_count < CNT_FULL);
   assign w_push  = (r_state == ST_WAIT) && bus.mem_ack && !redirect_valid;
   assign w_pop   = r_out_valid && bus.out_ready;
   // Acks that return data nobody wants any more.
   assign w_drop  = bus.mem_ack && ((r_state == ST_SQUASH) ||
                                    ((r_state == ST_WAIT) && redirect_valid));

   // Next queue occupancy, read pointer and head entry (feeds registered out_*).
   always_comb begin
      w_count_after_pop = w_pop ? (r_count - CNT_ONE) : r_count;
      w_count_nxt       = CNT_ZERO;
      w_rd_ptr_nxt      = PTR_ZERO;
      w_head_instr_nxt  = {DATA_W{1'b0}};
      w_head_pc_nxt     = {ADDR_W{1'b0}};
      if (redirect_valid) begin
         w_count_nxt  = CNT_ZERO;
         w_rd_ptr_nxt = PTR_ZERO;
      end else begin
         w_count_nxt  = w_count_after_pop + (w_push ? CNT_ONE : CNT_ZERO);
         w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
         if (w_count_nxt == CNT_ZERO) begin
            w_head_instr_nxt = {DATA_W{1'b0}};
            w_head_pc_nxt    = {ADDR_W{1'b0}};
         end else if (w_push && (w_count_after_pop == CNT_ZERO)) begin
            // Pushed word lands directly at the head (queue empty after pop).
            w_head_instr_nxt = bus.mem_rdata;
            w_head_pc_nxt    = r_mem_addr;
         end else begin
            w_head_instr_nxt = r_q_instr[w_rd_ptr_nxt];
            w_head_pc_nxt    = r_q_pc[w_rd_ptr_nxt];
         end
      end
   end

   // Fetch FSM: state, fetch PC and registered memory request outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_mem_req  <= 1'b0;
         r_mem_addr <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + PC_ONE;
                  r_state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end else if (redirect_valid) begin
                  // The memory transaction cannot be aborted: keep it alive
                  // with its old address and throw the data away on ack.
                  r_state <= ST_SQUASH;
               end
            end
            ST_SQUASH: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
         // Never collides with an issue: w_issue is low during a redirect.
         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
         end
      end
   end

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= {DATA_W{1'b0}};
            r_q_pc[i]    <= {ADDR_W{1'b0}};
         end
      end else if (redirect_valid) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else begin
         if (w_push) begin
            r_q_instr[r_wr_ptr] <= bus.mem_rdata;
            r_q_pc[r_wr_ptr]    <= r_mem_addr;
            r_wr_ptr            <= r_wr_ptr + PTR_ONE;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Registered decode-side outputs mirroring the next queue head.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_instr <= {DATA_W{1'b0}};
         r_out_pc    <= {ADDR_W{1'b0}};
      end else begin
         r_out_valid <= (w_count_nxt != CNT_ZERO);
         r_out_instr <= w_head_instr_nxt;
         r_out_pc    <= w_head_pc_nxt;
      end
   end

`ifdef PREFETCH_PERF_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_squash_cnt;

   // Performance counters: words pushed and acks discarded (wrap at 2^32).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_perf_fetch_cnt  <= 32'd0;
         r_perf_squash_cnt <= 32'd0;
      end else begin
         if (w_push) begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         end
         if (w_drop) begin
            r_perf_squash_cnt <= r_perf_squash_cnt + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt  = r_perf_fetch_cnt;
   assign perf_squash_cnt = r_perf_squash_cnt;
`endif

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.out_instr = r_out_instr;
   assign bus.out_pc    = r_out_pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
// Directed bench for instr_prefetch_queue. A small memory model answers reads
// with img(addr) after a programmable number of wait cycles; issued addresses
// and popped (pc, instr) pairs are recorded and compared against hand-derived
// expectations.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

   logic        clk;
   logic        reset;
   logic        halt;
   logic        redirect_valid;
   logic [18:0] redirect_pc;
`ifdef PREFETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_squash_cnt;
`endif

   instr_prefetch_queue_if #(.DATA_W(19), .ADDR_W(19)) bus ();

   instr_prefetch_queue #(
      .DATA_W   (19),
      .ADDR_W   (19),
      .DEPTH    (4),
      .RESET_PC (19'h00000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
`ifdef PREFETCH_PERF_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_squash_cnt (perf_squash_cnt)
`endif
   );

   int          n_tests;
   int          n_fail;
   int          ack_delay;
   int          wait_cnt;
   bit          auto_ack;
   logic        prev_req;
   logic [18:0] issued[$];
   logic [18:0] popped_pc[$];
   logic [18:0] popped_ins[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: instruction content as a function of its address.
   function automatic logic [18:0] img(input logic [18:0] a);
      return a ^ 19'h5A5A5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: log handshakes completing on this edge, then sample and
   // let the memory model decide mem_ack for the next edge.
   task automatic tick();
      if (bus.out_valid && bus.out_ready) begin
         popped_pc.push_back(bus.out_pc);
         popped_ins.push_back(bus.out_instr);
      end
      @(posedge clk);
      #1;
      if (bus.mem_req && !prev_req) issued.push_back(bus.mem_addr);
      prev_req = bus.mem_req;
      if (auto_ack) begin
         if (bus.mem_req && (wait_cnt >= ack_delay)) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = img(bus.mem_addr);
            wait_cnt      = 0;
         end else if (bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
         end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
         end
      end
   endtask

   task automatic clear_logs();
      issued.delete();
      popped_pc.delete();
      popped_ins.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      clear_logs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Watchdog: the directed sequence is far shorter than this.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 19'h00000;
      bus.out_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 19'h00000;
      auto_ack = 1'b1; ack_delay = 0; wait_cnt = 0; prev_req = 1'b0;

      // ---- 1: reset values, then streaming with immediate ack ----
      tick(); tick();
      check("rst_mem_req",   32'(bus.mem_req),   32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_instr", 32'(bus.out_instr), 32'd0);
      check("rst_out_pc",    32'(bus.out_pc),    32'd0);
`ifdef PREFETCH_PERF_EN
      check("rst_perf_fetch",  perf_fetch_cnt,  32'd0);
      check("rst_perf_squash", perf_squash_cnt, 32'd0);
`endif
      reset = 1'b1; bus.out_ready = 1'b1; clear_logs();
      tick();
      check("t1_first_req",  32'(bus.mem_req),  32'd1);
      check("t1_first_addr", 32'(bus.mem_addr), 32'd0);
      tick();
      check("t1_first_valid", 32'(bus.out_valid), 32'd1);
      check("t1_first_pc",    32'(bus.out_pc),    32'd0);
      check("t1_first_instr", 32'(bus.out_instr), 32'(img(19'h00000)));
      run(38);
      check("t1_npop", 32'(popped_pc.size() >= 12), 32'd1);
      for (int i = 0; i < 12; i++) begin
         check("t1_issue_addr", 32'(issued[i]),     32'(i));
         check("t1_pop_pc",     32'(popped_pc[i]),  32'(i));
         check("t1_pop_instr",  32'(popped_ins[i]), 32'(img(19'(i))));
      end

      // ---- 2: decode stalled, queue fills to DEPTH ----
      bus.out_ready = 1'b0;
      do_reset();
      run(20);
      check("t2_n_issued", 32'(issued.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t2_issue_addr", 32'(issued[i]), 32'(i));
      check("t2_req_idle",  32'(bus.mem_req),   32'd0);
      check("t2_valid",     32'(bus.out_valid), 32'd1);
      check("t2_head_pc",   32'(bus.out_pc),    32'd0);
      check("t2_head_ins",  32'(bus.out_instr), 32'(img(19'h00000)));
      bus.out_ready = 1'b1; clear_logs();
      run(8);
      check("t2_resume_addr", 32'(issued[0]), 32'd4);
      for (int i = 0; i < 4; i++) check("t2_drain_pc", 32'(popped_pc[i]), 32'(i));

      // ---- 3: redirect while read to addr 5 waits on a delayed ack ----
      ack_delay = 3; wait_cnt = 0;
      do_reset();
      for (int k = 0; k < 200; k++) begin
         if (bus.mem_req && (bus.mem_addr == 19'h00005)) break;
         tick();
      end
      check("t3_reach_addr5", 32'(bus.mem_req && (bus.mem_addr == 19'h00005)), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 19'h00100;
      tick();
      redirect_valid = 1'b0;
      check("t3_sq_req",   32'(bus.mem_req),   32'd1);
      check("t3_sq_addr",  32'(bus.mem_addr),  32'd5);
      check("t3_sq_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t3_sq_addr_hold", 32'(bus.mem_addr), 32'd5);
      tick();
      check("t3_sq_req_hold", 32'(bus.mem_req), 32'd1);
      tick();
      check("t3_after_ack_req",   32'(bus.mem_req),   32'd0);
      check("t3_after_ack_valid", 32'(bus.out_valid), 32'd0);
      clear_logs();
      run(20);
      check("t3_new_addr",  32'(issued[0]),     32'h100);
      check("t3_new_pc",    32'(popped_pc[0]),  32'h100);
      check("t3_new_instr", 32'(popped_ins[0]), 32'(img(19'h00100)));

      // ---- 4: redirect with same-cycle ack and pop ----
      ack_delay = 0; wait_cnt = 0; bus.out_ready = 1'b0;
      do_reset();
      run(3);
      check("t4_pre_req",   32'(bus.mem_req),   32'd1);
      check("t4_pre_addr",  32'(bus.mem_addr),  32'd1);
      check("t4_pre_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 19'h00200;
      tick();
      redirect_valid = 1'b0;
      check("t4_valid_cleared", 32'(bus.out_valid), 32'd0);
      check("t4_req_low",       32'(bus.mem_req),   32'd0);
`ifdef PREFETCH_PERF_EN
      check("t4_perf_fetch",  perf_fetch_cnt,  32'd1);
      check("t4_perf_squash", perf_squash_cnt, 32'd1);
`endif
      clear_logs();
      run(10);
      check("t4_first_pc",    32'(popped_pc[0]),  32'h200);
      check("t4_first_instr", 32'(popped_ins[0]), 32'(img(19'h00200)));

      // ---- 5: fetch PC wraps from 0x7FFFF to 0 ----
      redirect_valid = 1'b1; redirect_pc = 19'h7FFFF;
      tick();
      redirect_valid = 1'b0;
      clear_logs();
      run(8);
      check("t5_addr_top",  32'(issued[0]),    32'h7FFFF);
      check("t5_addr_wrap", 32'(issued[1]),    32'h00000);
      check("t5_pc_top",    32'(popped_pc[0]), 32'h7FFFF);
      check("t5_pc_wrap",   32'(popped_pc[1]), 32'h00000);

      // ---- halt blocks issue, release resumes from fetch PC ----
      halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 19'h00300;
      tick();
      redirect_valid = 1'b0;
      clear_logs();
      run(8);
      check("halt_no_issue", 32'(issued.size()),  32'd0);
      check("halt_req",      32'(bus.mem_req),    32'd0);
      check("halt_valid",    32'(bus.out_valid),  32'd0);
      halt = 1'b0;
      run(3);
      check("halt_resume_addr", 32'(issued[0]), 32'h300);

      // ---- 6: reset mid-WAIT, late ack after release ignored ----
      bus.out_ready = 1'b0; ack_delay = 3; wait_cnt = 0;
      run(12);
      for (int k = 0; k < 20; k++) begin
         if (bus.mem_req) break;
         tick();
      end
      check("t6_pre_req",   32'(bus.mem_req),   32'd1);
      check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
      auto_ack = 1'b0; bus.mem_ack = 1'b0; reset = 1'b0;
      tick();
      check("t6_rst_req",   32'(bus.mem_req),   32'd0);
      check("t6_rst_addr",  32'(bus.mem_addr),  32'd0);
      check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_instr", 32'(bus.out_instr), 32'd0);
      check("t6_rst_pc",    32'(bus.out_pc),    32'd0);
      reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 19'h12345;
      tick();
      bus.mem_ack = 1'b0;
      check("t6_late_ack_valid", 32'(bus.out_valid), 32'd0);
      check("t6_restart_req",    32'(bus.mem_req),   32'd1);
      check("t6_restart_addr",   32'(bus.mem_addr),  32'd0);
      auto_ack = 1'b1; ack_delay = 0; wait_cnt = 0; bus.out_ready = 1'b1;
      clear_logs();
      run(8);
      check("t6_first_pc",    32'(popped_pc[0]),  32'd0);
      check("t6_first_instr", 32'(popped_ins[0]), 32'(img(19'h00000)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Instruction fetch front-end sitting directly upstream of the CPU decode/execute stage. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned 19-bit instruction words are buffered with their PC in a small FIFO and presented to decode over a valid/ready interface. Branch/jump redirects flush the queue and squash any in-flight read.

Parameters:
DATA_W, 19, instruction word width
ADDR_W, 19, word-address width of fetch PC
DEPTH, 4, queue entries (power of 2, >=2)
RESET_PC, 0, fetch PC after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
halt  input  1  stop issuing new reads (HALT decoded); in-flight read still completes
redirect_valid  input  1  flush queue and load fetch PC
redirect_pc  input  ADDR_W  new fetch PC
mem_req  output  1  read request, held until acked
mem_addr  output  ADDR_W  read word address, stable while mem_req high
mem_ack  input  1  read complete, mem_rdata valid this cycle
mem_rdata  input  DATA_W  read data
out_valid  output  1  queue head valid
out_instr  output  DATA_W  head instruction
out_pc  output  ADDR_W  head instruction address
out_ready  input  1  decode accepts head

Behaviour:
- Reset (reset==0 at edge): fetch_pc=RESET_PC, queue empty, state IDLE; mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. Applies mid-transaction; a late mem_ack after reset is ignored (state IDLE).
- FSM states: IDLE, WAIT, WAIT_SQUASH.
- IDLE: if !halt and !redirect_valid and (count + 0) < DEPTH: register mem_req=1, mem_addr=fetch_pc; fetch_pc <= fetch_pc+1 (wraps 2^ADDR_W-1 -> 0); go WAIT. mem_req is a registered output, first high one cycle after the decision.
- WAIT: on mem_ack: push {mem_addr, mem_rdata}, mem_req=0, go IDLE. At most one read outstanding; a slot is reserved at issue, so push never overflows. mem_ack in IDLE is ignored.
- Issue is blocked when count==DEPTH, or count==DEPTH-1 is reserved by the outstanding read.
- Pop: out_valid && out_ready removes head; out_* update to next entry same edge. Simultaneous push and pop keep count unchanged.
- out_valid = (count != 0); out_instr/out_pc driven from head entry (0 when empty).
- Redirect (any state): queue cleared (count=0, out_valid=0 next cycle), fetch_pc=redirect_pc. Redirect wins over same-cycle push/pop/issue; the popped head that cycle is still considered consumed by decode. If in WAIT without mem_ack that cycle, go WAIT_SQUASH; if mem_ack same cycle, data discarded, go IDLE.
- WAIT_SQUASH: mem_req stays high with old mem_addr (memory transactions are not aborted); on mem_ack data discarded, go IDLE. A further redirect here only reloads fetch_pc.
- halt: blocks new issue only; queued entries still drain. Deassert resumes from fetch_pc.
- Throughput: with single-cycle ack, one instruction per 2 cycles; latency redirect -> first out_valid = 3 cycles with immediate ack.

Optional Feature:
PREFETCH_PERF_EN: when defined, adds outputs perf_fetch_cnt (32-bit, increments on each pushed word) and perf_squash_cnt (32-bit, increments per discarded ack, including same-cycle redirect+ack); both reset to 0, wrap at 2^32. When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
Reset release, memory acks 1 cycle after req, out_ready=1 -> mem_addr sequence 0,1,2,...; out_pc/out_instr match memory image in order, no gaps or duplicates.
out_ready=0 for 20 cycles -> exactly DEPTH=4 reads issued (addr 0..3), mem_req stays 0 afterwards, out_valid=1 holding pc 0; ready=1 resumes at addr 4.
Redirect to 0x100 while request to addr 5 waits on ack delayed 3 cycles -> addr 5 stays on mem_addr until ack, data dropped, next mem_addr=0x100, first out_pc=0x100.
Redirect with same-cycle mem_ack and out_ready pop -> queue empty next cycle, acked word never appears; with PREFETCH_PERF_EN perf_squash_cnt=1.
redirect_pc=0x7FFFF, run -> fetch addresses 0x7FFFF then 0x00000.
Assert reset=0 mid-WAIT, then mem_ack arrives after release -> ack ignored, outputs at reset values, fetch restarts at RESET_PC.
